layer_controller_neuron_mac: RTL and testbench

Multiply-accumulate neuron stage that sits directly downstream of the layer controller's per-neuron weight PIO registers. It consumes the exported 17-bit weight words and a 17-bit bias word. It accepts a stream of N_INPUTS signed fixed-point activations and computes bias + Σ x[i]·w[i]. It applies ReLU with saturation and presents one 17-bit result on a valid/ready output handshake for the next layer.

---
 rtl/ffnn_pkg.sv | 27 ++
 rtl/layer_controller_neuron_mult.sv | 26 ++
 rtl/layer_controller_neuron_mac.sv | 108 ++++++++++
 tb/tb_layer_controller_neuron_mac.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ffnn_pkg.sv
// Shared fixed-point definitions for the feed-forward network layers:
// format defaults, neuron FSM states and the ReLU/saturation helpers.
package ffnn_pkg;

    localparam int DATA_W_DEF    = 17;
    localparam int FRAC_BITS_DEF = 8;

    typedef enum logic [1:0] {IDLE, ACCUM, ACT, OUT} neuron_state_t;

    // Result is clamped to 0..2^(data_w-1)-1; callers truncate to data_w bits.
    function automatic logic [63:0] relu_sat(input logic signed [63:0] s,
                                             input int unsigned data_w);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        if (s < 0)
            return 64'd0;
        if (s > max_v)
            return max_v;
        return s;
    endfunction

    function automatic logic relu_sat_flag(input logic signed [63:0] s,
                                           input int unsigned data_w);
        return s > ((64'sd1 <<< (data_w - 1)) - 64'sd1);
    endfunction

endpackage

// File: rtl/layer_controller_neuron_mult.sv
// Registered signed DATA_W x DATA_W multiplier, one-cycle latency with a
// valid flag travelling alongside the product.
module layer_controller_neuron_mult #(
    parameter int DATA_W = 17
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    input  logic                       in_valid,
    output logic signed [2*DATA_W-1:0] product,
    output logic                       out_valid
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                product <= a * b;
        end
    end

endmodule

// File: rtl/layer_controller_neuron_mac.sv
// Neuron MAC stage: bias + sum(x[i]*w[i]) over a streamed activation vector,
// then ReLU with saturation, presented on a valid/ready output.
module layer_controller_neuron_mac
    import ffnn_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ACC_W     = 2*DATA_W + $clog2(N_INPUTS) + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_INPUTS*DATA_W-1:0]   weights,
    input  logic [DATA_W-1:0]            bias,
    input  logic                         start,
    input  logic [DATA_W-1:0]            x_data,
    input  logic                         x_valid,
    output logic                         x_ready,
    output logic [DATA_W-1:0]            y_data,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic                         busy,
    output logic                         overflow
);

    localparam int              CW    = $clog2(N_INPUTS + 1);
    localparam logic [CW-1:0]   N_CNT = CW'(N_INPUTS);

    neuron_state_t              state_q, state_d;
    logic [CW-1:0]              count;
    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] product;
    logic                       prod_valid;
    logic signed [DATA_W-1:0]   w_sel;
    logic                       x_fire;
    logic signed [63:0]         s64;

    // Only meaningful while count < N_INPUTS, i.e. when x_ready can be high.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_INPUTS; i++)
            if (count == CW'(i))
                w_sel = weights[i*DATA_W +: DATA_W];
    end

    assign x_ready = (state_q == ACCUM) && (count < N_CNT);
    assign x_fire  = x_valid && x_ready;
    assign y_valid = (state_q == OUT);
    assign busy    = (state_q != IDLE);
    assign s64     = 64'(acc >>> FRAC_BITS);

    layer_controller_neuron_mult #(.DATA_W(DATA_W)) u_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (x_data),
        .b         (w_sel),
        .in_valid  (x_fire),
        .product   (product),
        .out_valid (prod_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            // Wait for the last product to drain into the accumulator.
            ACCUM:   if (count == N_CNT && !prod_valid) state_d = ACT;
            ACT:     state_d = OUT;
            OUT:     if (y_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            acc      <= '0;
            y_data   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    acc   <= ACC_W'($signed(bias)) <<< FRAC_BITS;
                    count <= '0;
                end
                ACCUM: begin
                    if (x_fire)
                        count <= count + 1'b1;
                    if (prod_valid)
                        acc <= acc + ACC_W'(product);
                end
                ACT: begin
                    y_data   <= DATA_W'(relu_sat(s64, DATA_W));
                    overflow <= relu_sat_flag(s64, DATA_W);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_controller_neuron_mac.sv
// Directed bench for layer_controller_neuron_mac with a result scoreboard.
module tb_layer_controller_neuron_mac;

    localparam int N  = 4;
    localparam int DW = 17;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N*DW-1:0] weights;
    logic [DW-1:0]   bias, x_data, y_data;
    logic            start, x_valid, x_ready, y_valid, y_ready, busy, overflow;

    typedef struct {
        logic [DW-1:0] y;
        logic          ovf;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     start_cyc;
    longint w_one[N], w_sat[N], w_var[N];
    longint x_basic[N], x_one[N], x_half[N], x_sat[N];

    layer_controller_neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .FRAC_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .weights(weights), .bias(bias),
        .start(start), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads the PIOs, pushes the modelled result and issues start (edge 0).
    task automatic begin_run(input longint b, input longint w[N], input longint xs[N]);
        longint acc, s;
        exp_t   e;
        logic [63:0] tmp;
        bias = b[DW-1:0];
        for (int i = 0; i < N; i++) begin
            tmp = w[i];
            weights[i*DW +: DW] = tmp[DW-1:0];
        end
        acc = b * 256;
        for (int i = 0; i < N; i++) acc += xs[i] * w[i];
        s = acc >>> 8;
        if (s < 0)            begin e.y = '0;        e.ovf = 1'b0; end
        else if (s > 65535)   begin e.y = 17'd65535; e.ovf = 1'b1; end
        else                  begin tmp = s; e.y = tmp[DW-1:0]; e.ovf = 1'b0; end
        sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_x(input longint x);
        int t = 0;
        logic [63:0] tmp;
        tmp = x;
        x_data  = tmp[DW-1:0];
        x_valid = 1'b1;
        while (!x_ready && t < 20) begin tick(); t++; end
        chk("x_ready_wait", {63'd0, x_ready}, 64'd1);
        tick();
        x_valid = 1'b0;
    endtask

    task automatic send_all(input longint xs[N], input int gap_at, input int gap);
        for (int i = 0; i < N; i++) begin
            if (i == gap_at) repeat (gap) tick();
            send_x(xs[i]);
        end
    endtask

    // Waits for y_valid, checks latency, holds backpressure, pops and compares.
    task automatic end_run(input string tag, input int lat, input int hold,
                           input bit pulse_start, input bit ready_early);
        int   t = 0;
        exp_t e;
        e = sb.pop_front();
        if (ready_early) y_ready = 1'b1;
        while (!y_valid && t < 40) begin tick(); t++; end
        chk({tag, "_latency"}, 64'(cyc - start_cyc), 64'(lat));
        for (int k = 0; k < hold; k++) begin
            start = pulse_start && (k == 1);
            tick();
            start = 1'b0;
            chk({tag, "_hold_valid"}, {63'd0, y_valid}, 64'd1);
            chk({tag, "_hold_data"}, 64'(y_data), 64'(e.y));
        end
        y_ready = 1'b1;
        chk({tag, "_y_data"}, 64'(y_data), 64'(e.y));
        chk({tag, "_overflow"}, {63'd0, overflow}, {63'd0, e.ovf});
        tick();
        y_ready = 1'b0;
        chk({tag, "_valid_drop"}, {63'd0, y_valid}, 64'd0);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; x_valid = 1'b0; y_ready = 1'b0;
        x_data = '0; bias = '0; weights = '0;
        for (int i = 0; i < N; i++) begin
            w_one[i] = 256; w_sat[i] = 32767; w_var[i] = 256 * (i + 1);
            x_one[i] = 256; x_half[i] = 128; x_sat[i] = 32767;
        end
        x_basic[0] = 256; x_basic[1] = 512; x_basic[2] = -256; x_basic[3] = 0;

        repeat (2) tick();
        chk("rst_x_ready", {63'd0, x_ready}, 64'd0);
        chk("rst_y_valid", {63'd0, y_valid}, 64'd0);
        chk("rst_y_data", 64'(y_data), 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        reset_n = 1'b1;
        tick();

        begin_run(0, w_one, x_basic);      send_all(x_basic, -1, 0); end_run("basic", 7, 0, 0, 0);
        begin_run(-1024, w_one, x_one);    send_all(x_one, -1, 0);   end_run("bias_zero", 7, 0, 0, 0);
        begin_run(256, w_one, x_one);      send_all(x_one, -1, 0);   end_run("bias_pos", 7, 0, 0, 0);
        begin_run(-1024, w_one, x_half);   send_all(x_half, -1, 0);  end_run("neg_clamp", 7, 0, 0, 0);
        begin_run(0, w_sat, x_sat);        send_all(x_sat, -1, 0);   end_run("saturate", 7, 0, 0, 0);
        begin_run(0, w_one, x_basic);      send_all(x_basic, -1, 0); end_run("ovf_clear", 7, 0, 0, 0);
        begin_run(0, w_var, x_one);        send_all(x_one, -1, 0);   end_run("weight_idx", 7, 0, 0, 0);
        begin_run(0, w_one, x_basic);      send_all(x_basic, 2, 3);  end_run("stall", 10, 0, 0, 0);
        begin_run(256, w_one, x_one);      send_all(x_one, -1, 0);   end_run("backpr", 7, 5, 1, 0);
        begin_run(0, w_one, x_basic);      send_all(x_basic, -1, 0); end_run("ready_early", 7, 0, 0, 1);

        // Abort after two inputs: the pushed result is withdrawn.
        begin_run(0, w_one, x_basic);
        send_x(x_basic[0]);
        send_x(x_basic[1]);
        reset_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("abort_x_ready", {63'd0, x_ready}, 64'd0);
        chk("abort_y_valid", {63'd0, y_valid}, 64'd0);
        chk("abort_y_data", 64'(y_data), 64'd0);
        chk("abort_overflow", {63'd0, overflow}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("abort_still_idle", {63'd0, y_valid | busy}, 64'd0);
        begin_run(0, w_one, x_basic);      send_all(x_basic, -1, 0); end_run("after_abort", 7, 0, 0, 0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
